// File: rtl/store_buffer_if.sv
// Store buffer bus: push port from the memory stage, drain port to data memory,
// load-check port and status. The slave side is the buffer itself.
interface store_buffer_if #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int LANES = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  pushValid;
  logic [ADDR_WIDTH-1:0] pushAddress;
  logic [DATA_WIDTH-1:0] pushData;
  logic [LANES-1:0]      pushByteEnable;
  logic                  pushReady;

  logic                  memValid;
  logic [ADDR_WIDTH-1:0] memAddress;
  logic [DATA_WIDTH-1:0] memData;
  logic [LANES-1:0]      memByteEnable;
  logic                  memComplete;

  logic                  loadQueryValid;
  logic [ADDR_WIDTH-1:0] loadQueryAddress;
  logic [LANES-1:0]      loadQueryByteEnable;
  logic                  loadForwardHit;
  logic [DATA_WIDTH-1:0] loadForwardData;
  logic                  loadBlock;

  logic                  bufferEmpty;
  logic [CNT_W-1:0]      bufferCount;

  modport slave (
    input  pushValid, pushAddress, pushData, pushByteEnable, memComplete,
           loadQueryValid, loadQueryAddress, loadQueryByteEnable,
    output pushReady, memValid, memAddress, memData, memByteEnable,
           loadForwardHit, loadForwardData, loadBlock, bufferEmpty, bufferCount
  );

  modport master (
    output pushValid, pushAddress, pushData, pushByteEnable, memComplete,
           loadQueryValid, loadQueryAddress, loadQueryByteEnable,
    input  pushReady, memValid, memAddress, memData, memByteEnable,
           loadForwardHit, loadForwardData, loadBlock, bufferEmpty, bufferCount
  );
endinterface

// File: rtl/store_buffer.sv
// In-order store buffer: queues retired stores in a ring, drains the head over a
// valid/complete handshake, and forwards or blocks loads that overlap queued stores.
module store_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  store_buffer_if.slave    bus
);
  localparam int LANES  = DATA_WIDTH / 8;
  localparam int OFF    = $clog2(LANES);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WORD_W = ADDR_WIDTH - OFF;

  typedef struct packed {
    logic [WORD_W-1:0]     word;
    logic [DATA_WIDTH-1:0] data;
    logic [LANES-1:0]      be;
  } entry_t;

  typedef enum logic {
    DRAIN_IDLE = 1'b0,
    DRAIN_BUSY = 1'b1
  } drain_state_t;

  entry_t           entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  drain_state_t     state;
  drain_state_t     state_next;

  logic mem_valid;
  logic push_fire;
  logic pop_fire;

  assign mem_valid     = (state == DRAIN_BUSY);
  assign bus.pushReady = (count != CNT_W'(DEPTH));
  assign push_fire     = bus.pushValid && bus.pushReady;
  assign pop_fire      = mem_valid && bus.memComplete;

  // NOTE: the payload array has no reset; the valid bits and pointers alone
  // define which entries exist, so clearing the data would only cost flops.
  always_ff @(posedge clock) begin
    if (push_fire) begin
      entries[tail] <= '{word: bus.pushAddress[ADDR_WIDTH-1:OFF],
                         data: bus.pushData,
                         be:   bus.pushByteEnable};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
      state <= DRAIN_IDLE;
    end else begin
      // Push targets the tail and pop the head; they never share an index
      // because a full buffer refuses pushes and an empty one cannot pop.
      if (push_fire) begin
        valid[tail] <= 1'b1;
        tail        <= tail + 1'b1;
      end
      if (pop_fire) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      count <= count_next;
      state <= state_next;
    end
  end

  always_comb begin
    count_next = count;
    case ({push_fire, pop_fire})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // Presenting the head always follows an idle cycle, so each store costs two.
  always_comb begin
    state_next = state;
    case (state)
      DRAIN_IDLE: if (count != '0)      state_next = DRAIN_BUSY;
      DRAIN_BUSY: if (bus.memComplete)  state_next = DRAIN_IDLE;
      default:                          state_next = DRAIN_IDLE;
    endcase
  end

  assign bus.memValid      = mem_valid;
  assign bus.memAddress    = mem_valid ? {entries[head].word, {OFF{1'b0}}} : '0;
  assign bus.memData       = mem_valid ? entries[head].data : '0;
  assign bus.memByteEnable = mem_valid ? entries[head].be   : '0;
  assign bus.bufferEmpty   = (count == '0) && !mem_valid;
  assign bus.bufferCount   = count;

  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] needed_mask;
  logic [LANES-1:0]      covered;
  logic [LANES-1:0]      needed_cov;
  logic [PTR_W-1:0]      idx;
  logic                  hit;
  logic                  block;

  // Walk oldest to youngest so a younger store overwrites older lanes.
  always_comb begin
    merged      = '0;
    covered     = '0;
    needed_mask = '0;
    idx         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (valid[idx] && entries[idx].word == bus.loadQueryAddress[ADDR_WIDTH-1:OFF]) begin
        for (int l = 0; l < LANES; l++) begin
          if (entries[idx].be[l]) begin
            merged[l*8 +: 8] = entries[idx].data[l*8 +: 8];
            covered[l]       = 1'b1;
          end
        end
      end
    end
    for (int l = 0; l < LANES; l++) begin
      needed_mask[l*8 +: 8] = {8{bus.loadQueryByteEnable[l]}};
    end
  end

  assign needed_cov = covered & bus.loadQueryByteEnable;
  assign hit   = bus.loadQueryValid && (bus.loadQueryByteEnable != '0)
                 && (needed_cov == bus.loadQueryByteEnable);
  assign block = bus.loadQueryValid && (needed_cov != '0)
                 && (needed_cov != bus.loadQueryByteEnable);

  assign bus.loadForwardHit  = hit;
  assign bus.loadBlock       = block;
  assign bus.loadForwardData = hit ? (merged & needed_mask) : '0;

  // Byte offsets are implied by the lane enables and deliberately ignored.
  logic unused_offsets;
  assign unused_offsets = ^{bus.pushAddress[OFF-1:0], bus.loadQueryAddress[OFF-1:0]};

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed corner sequences, a table of load
// queries with fixed expectations, and random traffic against a queue-based model.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  store_buffer_if #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  store_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: program-ordered queue of stores plus the "presented" flag.
  typedef struct {
    logic [29:0] word;
    logic [31:0] data;
    logic [3:0]  be;
  } st_t;

  st_t         q[$];
  bit          m_valid = 1'b0;
  logic [31:0] drained[$];
  int          back_to_back = 0;
  bit          prev_mv = 1'b0;

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m = '0;
    for (int l = 0; l < 4; l++) if (be[l]) m[l*8 +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic void model_load(output bit hit, output bit block, output logic [31:0] data);
    logic [3:0]  cov    = '0;
    logic [31:0] merged = '0;
    logic [3:0]  need   = bus.loadQueryByteEnable;
    hit = 1'b0; block = 1'b0; data = '0;
    if (!bus.loadQueryValid || need == 4'b0) return;
    foreach (q[k]) begin
      if (q[k].word == bus.loadQueryAddress[31:2]) begin
        for (int l = 0; l < 4; l++) begin
          if (q[k].be[l]) begin
            merged[l*8 +: 8] = q[k].data[l*8 +: 8];
            cov[l] = 1'b1;
          end
        end
      end
    end
    hit   = ((cov & need) == need);
    block = ((cov & need) != 4'b0) && !hit;
    data  = hit ? (merged & lane_mask(need)) : 32'h0;
  endfunction

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    bit          e_hit, e_block;
    logic [31:0] e_data;
    bit          push_ok, pop;
    @(negedge clock);
    model_load(e_hit, e_block, e_data);
    check("pushReady", bus.pushReady, q.size() != DEPTH);
    check("memValid",  bus.memValid,  m_valid);
    check("memAddress",    bus.memAddress,    (m_valid && q.size() > 0) ? {q[0].word, 2'b00} : 32'h0);
    check("memData",       bus.memData,       (m_valid && q.size() > 0) ? q[0].data : 32'h0);
    check("memByteEnable", bus.memByteEnable, (m_valid && q.size() > 0) ? q[0].be   : 4'h0);
    check("bufferCount",   bus.bufferCount,   q.size());
    check("bufferEmpty",   bus.bufferEmpty,   (q.size() == 0) && !m_valid);
    check("loadForwardHit",  bus.loadForwardHit,  e_hit);
    check("loadBlock",       bus.loadBlock,       e_block);
    check("loadForwardData", bus.loadForwardData, e_data);
    if (bus.memValid && bus.memComplete) drained.push_back(bus.memAddress);
    if (bus.memValid && prev_mv) back_to_back++;
    prev_mv = bus.memValid;
    @(posedge clock);
    if (!reset) begin
      q.delete();
      m_valid = 1'b0;
    end else begin
      push_ok = bus.pushValid && (q.size() != DEPTH);
      pop     = m_valid && bus.memComplete;
      if (pop)                           m_valid = 1'b0;
      else if (!m_valid && q.size() > 0) m_valid = 1'b1;
      if (pop) void'(q.pop_front());
      if (push_ok) q.push_back('{word: bus.pushAddress[31:2], data: bus.pushData, be: bus.pushByteEnable});
    end
    #1;
  endtask

  task automatic idle();
    bus.pushValid = 0; bus.pushAddress = '0; bus.pushData = '0; bus.pushByteEnable = '0;
    bus.memComplete = 0;
    bus.loadQueryValid = 0; bus.loadQueryAddress = '0; bus.loadQueryByteEnable = '0;
  endtask

  task automatic set_push(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.pushValid = v; bus.pushAddress = a; bus.pushData = d; bus.pushByteEnable = be;
  endtask

  task automatic drain(input int cycles);
    bus.memComplete = 1;
    repeat (cycles) step();
    bus.memComplete = 0;
  endtask

  typedef struct {
    bit          qv;
    logic [31:0] addr;
    logic [3:0]  be;
    bit          hit;
    bit          block;
    logic [31:0] data;
  } vec_t;

  vec_t tbl[10];

  task automatic run_vectors(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bus.loadQueryValid      = tbl[i].qv;
      bus.loadQueryAddress    = tbl[i].addr;
      bus.loadQueryByteEnable = tbl[i].be;
      #2;
      check($sformatf("vec%0d_hit", i),   bus.loadForwardHit,  tbl[i].hit);
      check($sformatf("vec%0d_block", i), bus.loadBlock,       tbl[i].block);
      check($sformatf("vec%0d_data", i),  bus.loadForwardData, tbl[i].data);
      step();
    end
    bus.loadQueryValid = 0; bus.loadQueryAddress = '0; bus.loadQueryByteEnable = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_drain [5];
    // Forwarding merge: SB AA@201, SW 11223344@200, SB 55@203.
    tbl[0] = '{1, 32'h200, 4'b1111, 1, 0, 32'h55223344};
    tbl[1] = '{1, 32'h201, 4'b0010, 1, 0, 32'h00003300};
    tbl[2] = '{1, 32'h203, 4'b1000, 1, 0, 32'h55000000};
    tbl[3] = '{1, 32'h204, 4'b1111, 0, 0, 32'h0};
    tbl[4] = '{1, 32'h200, 4'b0000, 0, 0, 32'h0};
    // Partial overlap: only SH BEEF@300 queued.
    tbl[5] = '{1, 32'h300, 4'b1111, 0, 1, 32'h0};
    tbl[6] = '{1, 32'h302, 4'b0100, 0, 0, 32'h0};
    tbl[7] = '{1, 32'h301, 4'b0010, 1, 0, 32'h0000BE00};
    tbl[8] = '{1, 32'h300, 4'b0011, 1, 0, 32'h0000BEEF};
    tbl[9] = '{0, 32'h300, 4'b0011, 0, 0, 32'h0};
    exp_drain = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};

    idle();
    reset = 0;
    repeat (2) step();
    check("rst_pushReady", bus.pushReady, 1);
    check("rst_empty",     bus.bufferEmpty, 1);
    check("rst_memValid",  bus.memValid, 0);
    check("rst_memAddr",   bus.memAddress, 0);
    check("rst_fwd",       {bus.loadForwardHit, bus.loadBlock, bus.loadForwardData}, 0);
    reset = 1;
    step();

    // Fill to full, hold a fifth push, then push+complete in the same cycle.
    drained.delete();
    for (int i = 0; i < 4; i++) begin
      set_push(1, 32'h100 + 32'(4*i), 32'hA0 + 32'(i), 4'hF);
      step();
    end
    set_push(1, 32'h110, 32'hA4, 4'hF);
    #2;
    check("full_ready", bus.pushReady, 0);
    check("full_count", bus.bufferCount, 4);
    step();
    check("held_ready", bus.pushReady, 0);
    bus.memComplete = 1;
    #2;
    check("simul_mv", bus.memValid, 1);
    step();
    check("simul_count", bus.bufferCount, 3);
    bus.memComplete = 0;
    step();
    set_push(0, 0, 0, 0);
    #2;
    check("refill_count", bus.bufferCount, 4);
    back_to_back = 0;
    prev_mv = 0;
    drain(12);
    check("drain_len", drained.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("drain_addr%0d", i), (i < drained.size()) ? drained[i] : 32'hDEAD, exp_drain[i]);
    check("idle_between", back_to_back, 0);
    check("drain_empty", bus.bufferEmpty, 1);

    // Reset while a store is being presented with three queued.
    for (int i = 0; i < 3; i++) begin
      set_push(1, 32'h400 + 32'(4*i), 32'hC0 + 32'(i), 4'hF);
      step();
    end
    set_push(0, 0, 0, 0);
    step();
    check("mid_mv", bus.memValid, 1);
    check("mid_count", bus.bufferCount, 3);
    reset = 0;
    #1;
    check("async_mv", bus.memValid, 0);
    check("async_count", bus.bufferCount, 0);
    q.delete();
    m_valid = 0;
    step();
    reset = 1;
    step();
    check("post_rst_empty", bus.bufferEmpty, 1);
    check("post_rst_count", bus.bufferCount, 0);

    // Forward merge, youngest wins.
    set_push(1, 32'h201, 32'h0000AA00, 4'b0010); step();
    set_push(1, 32'h200, 32'h11223344, 4'b1111); step();
    set_push(1, 32'h203, 32'h55000000, 4'b1000); step();
    set_push(0, 0, 0, 0);
    run_vectors(0, 4);
    drain(8);

    // Partial overlap blocks; disjoint lanes go to memory.
    set_push(1, 32'h300, 32'h0000BEEF, 4'b0011); step();
    set_push(0, 0, 0, 0);
    run_vectors(5, 9);
    drain(4);
    check("sh_drained", bus.bufferEmpty, 1);

    // Random traffic on four words so loads overlap often.
    repeat (600) begin
      int          w, lo;
      logic [3:0]  be;
      w  = $urandom_range(0, 3);
      be = 4'($urandom_range(1, 15));
      lo = 0;
      for (int l = 3; l >= 0; l--) if (be[l]) lo = l;
      set_push($urandom_range(0, 1) == 1, 32'h500 + 32'(4*w + lo), $urandom, be);
      bus.memComplete = ($urandom_range(0, 2) == 0);
      w  = $urandom_range(0, 3);
      bus.loadQueryValid      = ($urandom_range(0, 3) != 0);
      bus.loadQueryByteEnable = 4'($urandom_range(0, 15));
      bus.loadQueryAddress    = 32'h500 + 32'(4*w);
      step();
    end
    idle();
    drain(12);
    check("final_empty", bus.bufferEmpty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
